// File: rtl/pwm_speed_ctrl_if.sv
// Button inputs and PWM control outputs exchanged between the board front-end and the PWM stage.
interface pwm_speed_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_en;
    logic       enable;
    logic [2:0] speed;
    logic [2:0] target;
    logic       speed_chg;

    modport master (
        output btn_up, btn_down, btn_en,
        input  enable, speed, target, speed_chg
    );

    modport slave (
        input  btn_up, btn_down, btn_en,
        output enable, speed, target, speed_chg
    );
endinterface

// File: rtl/pwm_speed_ctrl.sv
// Button front-end for the PWM stage: synchronize, debounce, press-detect, then ramp the
// applied speed one step per ramp period toward a saturating target.
module pwm_speed_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RAMP_CYCLES     = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_speed_ctrl_if.slave  bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

    // Button index: 0 = up, 1 = down, 2 = enable.
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1, r_sync2;
    logic [2:0]    r_deb, r_deb_q, r_press;
    logic [DW-1:0] r_cnt [3];

    logic          r_enable;
    logic [2:0]    r_speed;
    logic [2:0]    r_target;
    logic          r_speed_chg;
    logic [RW-1:0] r_ramp;

    logic          w_tick;
    logic          w_disable;
    logic [2:0]    w_target_next;
    logic [2:0]    w_speed_next;

    assign w_raw = {bus.btn_en, bus.btn_down, bus.btn_up};

    // NOTE: state is written with <= so every flop samples pre-edge values; blocking here
    // would let r_sync2 see this cycle's r_sync1 and collapse the synchronizer to one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            r_press <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DW'(1);
                end
            end
            r_deb_q <= r_deb;
            r_press <= r_deb & ~r_deb_q;
        end
    end

    assign w_tick    = r_enable && (r_ramp == RAMP_LAST);
    assign w_disable = r_enable && r_press[2];

    // NOTE: each always_comb output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_target_next = r_target;
        if (r_press[0] && !r_press[1] && r_target != 3'd7)
            w_target_next = r_target + 3'd1;
        else if (r_press[1] && !r_press[0] && r_target != 3'd0)
            w_target_next = r_target - 3'd1;
    end

    // Ticks compare against the current target, so a target change lands on the next tick.
    always_comb begin
        w_speed_next = r_speed;
        if (w_disable)
            w_speed_next = 3'd0;
        else if (w_tick && r_speed < r_target)
            w_speed_next = r_speed + 3'd1;
        else if (w_tick && r_speed > r_target)
            w_speed_next = r_speed - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable    <= 1'b0;
            r_speed     <= 3'd0;
            r_target    <= 3'd0;
            r_speed_chg <= 1'b0;
            r_ramp      <= '0;
        end else begin
            r_target    <= w_target_next;
            r_speed     <= w_speed_next;
            r_speed_chg <= (w_speed_next != r_speed);
            if (r_press[2])
                r_enable <= ~r_enable;
            if (!r_enable || w_disable || r_ramp == RAMP_LAST)
                r_ramp <= '0;
            else
                r_ramp <= r_ramp + RW'(1);
        end
    end

    assign bus.enable    = r_enable;
    assign bus.speed     = r_speed;
    assign bus.target    = r_target;
    assign bus.speed_chg = r_speed_chg;
endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Directed bench for pwm_speed_ctrl with DEBOUNCE_CYCLES=4, RAMP_CYCLES=8.
module tb_pwm_speed_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct { int cyc; logic [2:0] v; } chg_t;
    chg_t       chg_q[$];
    int         cyc = 0;
    int         chg_total = 0;
    logic [2:0] mon_last = 3'd0;

    pwm_speed_ctrl_if bus ();

    pwm_speed_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RAMP_CYCLES    (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.speed_chg === 1'b1) chg_total++;
        if (bus.speed !== mon_last) begin
            chg_q.push_back('{cyc, bus.speed});
            mon_last = bus.speed;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       bus.btn_up   = v;
            1:       bus.btn_down = v;
            default: bus.btn_en   = v;
        endcase
    endtask

    task automatic press(input int which, input int hold, input int gap);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_enable(input logic want);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (bus.enable === want) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_enable: enable=%b never reached %b", bus.enable, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.enable, bus.speed, bus.target, bus.speed_chg} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: en=%b spd=%0d tgt=%0d chg=%b, want all 0",
                     bus.enable, bus.speed, bus.target, bus.speed_chg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_debounce_reject();
        repeat (5) press(0, 3, 2);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.target !== 3'd0) begin
            errors++;
            $display("FAIL debounce_reject_target: got %0d want 0", bus.target);
        end
        checks++;
        if (chg_total != 0) begin
            errors++;
            $display("FAIL debounce_reject_chg: speed_chg pulses %0d want 0", chg_total);
        end
    endtask

    task automatic test_press_latency_sat();
        int         lat = -1;
        logic [2:0] old;
        old = bus.target;
        set_btn(0, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && bus.target !== old) lat = n;
        end
        @(negedge clk);
        set_btn(0, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL press_latency: %0d edges want 7", lat);
        end
        checks++;
        if (bus.target !== 3'd1) begin
            errors++;
            $display("FAIL up_press_1: target %0d want 1", bus.target);
        end
        for (int i = 2; i <= 9; i++) begin
            press(0, 10, 10);
            checks++;
            if (bus.target !== 3'((i > 7) ? 7 : i)) begin
                errors++;
                $display("FAIL up_press_%0d: target %0d want %0d", i, bus.target, (i > 7) ? 7 : i);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            press(1, 10, 10);
            checks++;
            if (bus.target !== 3'((7 - i < 0) ? 0 : 7 - i)) begin
                errors++;
                $display("FAIL down_press_%0d: target %0d want %0d", i, bus.target,
                         (7 - i < 0) ? 0 : 7 - i);
            end
        end
    endtask

    task automatic test_simultaneous();
        press(0, 10, 10);
        press(0, 10, 10);
        set_btn(0, 1'b1);
        set_btn(1, 1'b1);
        repeat (12) @(negedge clk);
        set_btn(0, 1'b0);
        set_btn(1, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.target !== 3'd2) begin
            errors++;
            $display("FAIL simultaneous: target %0d want 2", bus.target);
        end
        press(0, 10, 10);
        checks++;
        if (bus.target !== 3'd3) begin
            errors++;
            $display("FAIL up_after_simultaneous: target %0d want 3", bus.target);
        end
    endtask

    task automatic test_ramp();
        int t_en;
        int pulses = 0;
        press(0, 10, 10);
        press(0, 10, 10);
        checks++;
        if (bus.target !== 3'd5) begin
            errors++;
            $display("FAIL ramp_target: target %0d want 5", bus.target);
        end
        set_btn(2, 1'b1);
        wait_enable(1'b1);
        t_en = cyc;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            if (k == 5) set_btn(2, 1'b0);
            if (bus.speed_chg === 1'b1) pulses++;
            checks++;
            if (bus.speed !== 3'(((k / 8) > 5) ? 5 : (k / 8)) ||
                bus.speed_chg !== ((k % 8 == 0) && (k <= 40))) begin
                errors++;
                $display("FAIL ramp_k%0d: speed %0d chg %b want speed %0d chg %b", k, bus.speed,
                         bus.speed_chg, ((k / 8) > 5) ? 5 : (k / 8), (k % 8 == 0) && (k <= 40));
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL ramp_pulses: %0d want 5", pulses);
        end
        chg_q.delete();
        press(1, 10, 10);
        press(1, 10, 10);
        repeat (24) @(negedge clk);
        checks++;
        if (chg_q.size() != 2 || bus.target !== 3'd3) begin
            errors++;
            $display("FAIL ramp_down_count: changes %0d target %0d want 2 and 3", chg_q.size(),
                     bus.target);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (chg_q[i].v !== 3'(4 - i) || ((chg_q[i].cyc - t_en) % 8) != 0) begin
                    errors++;
                    $display("FAIL ramp_down_%0d: speed %0d at +%0d want %0d on a multiple of 8",
                             i, chg_q[i].v, chg_q[i].cyc - t_en, 4 - i);
                end
            end
        end
    endtask

    task automatic test_disable_mid_ramp();
        do_reset();
        repeat (6) press(0, 10, 10);
        set_btn(2, 1'b1);
        wait_enable(1'b1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 5) set_btn(2, 1'b0);
            if (k == 20) set_btn(2, 1'b1);
            if (k == 27) begin
                checks++;
                if (bus.enable !== 1'b1 || bus.speed !== 3'd3) begin
                    errors++;
                    $display("FAIL pre_disable: en %b speed %0d want 1 and 3", bus.enable,
                             bus.speed);
                end
            end
            if (k == 28) begin
                checks++;
                if ({bus.enable, bus.speed, bus.speed_chg, bus.target} !== {1'b0, 3'd0, 1'b1, 3'd6}) begin
                    errors++;
                    $display("FAIL disable_edge: en %b speed %0d chg %b tgt %0d want 0 0 1 6",
                             bus.enable, bus.speed, bus.speed_chg, bus.target);
                end
            end
            if (k == 29) begin
                checks++;
                if (bus.speed_chg !== 1'b0 || bus.speed !== 3'd0) begin
                    errors++;
                    $display("FAIL disable_after: chg %b speed %0d want 0 and 0", bus.speed_chg,
                             bus.speed);
                end
            end
        end
        set_btn(2, 1'b0);
        repeat (10) @(negedge clk);
        set_btn(2, 1'b1);
        wait_enable(1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) set_btn(2, 1'b0);
            checks++;
            if (bus.speed !== 3'((k == 8) ? 1 : 0) || bus.speed_chg !== (k == 8)) begin
                errors++;
                $display("FAIL reenable_k%0d: speed %0d chg %b want %0d %b", k, bus.speed,
                         bus.speed_chg, (k == 8) ? 1 : 0, k == 8);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat = -1;
        set_btn(0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.enable, bus.speed, bus.target, bus.speed_chg} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: en=%b spd=%0d tgt=%0d chg=%b want all 0",
                     bus.enable, bus.speed, bus.target, bus.speed_chg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && bus.target !== 3'd0) lat = n;
        end
        @(negedge clk);
        set_btn(0, 1'b0);
        checks++;
        if (lat != 7 || bus.target !== 3'd1 || bus.enable !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_press: latency %0d tgt %0d en %b want 7 1 0", lat,
                     bus.target, bus.enable);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_debounce_reject();
        test_press_latency_sat();
        test_simultaneous();
        test_ramp();
        test_disable_mid_ramp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
